// File: rtl/multi_chan_down_counter_pkg.sv
// Shared types for the multi-channel down-counter timer bank.
// Optional sticky terminal-count flags: MULTI_CHAN_DOWN_COUNTER_STICKY_EN.
package multi_chan_down_counter_pkg;

    typedef enum logic [1:0] {
        NOP           = 2'd0,
        LOAD_ONESHOT  = 2'd1,
        LOAD_PERIODIC = 2'd2,
        STOP          = 2'd3
    } cmd_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_e;

    typedef enum logic {
        ONESHOT  = 1'b0,
        PERIODIC = 1'b1
    } mode_e;

    // Channel-select width; a single-channel bank still gets a 1-bit select.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multi_chan_down_counter_chan.sv
// One timer channel: IDLE/RUN state, count, reload value, mode and tc pulse.
// A load or stop strobe overrides the normal count step on the same edge.
module multi_chan_down_counter_chan
    import multi_chan_down_counter_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena_i,
    input  logic             load_i,
    input  logic             stop_i,
    input  logic             periodic_i,
    input  logic [WIDTH-1:0] value_i,
    output logic             tc_o,
    output logic [WIDTH-1:0] cnt_o,
    output chan_state_e      state_o
);

    chan_state_e      state_q;
    mode_e            mode_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] reload_q;
    logic             tc_q;
    logic             tc_d;

    // Expiry pulses even when a command lands on this channel at the same edge.
    assign tc_d = (state_q == RUN) && ena_i && (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mode_q   <= ONESHOT;
            cnt_q    <= RESET_VAL;
            reload_q <= RESET_VAL;
            tc_q     <= 1'b0;
        end else begin
            tc_q <= tc_d;
            if (load_i) begin
                cnt_q    <= value_i;
                reload_q <= value_i;
                mode_q   <= periodic_i ? PERIODIC : ONESHOT;
                state_q  <= RUN;
            end else if (stop_i) begin
                state_q <= IDLE;
            end else if (state_q == RUN && ena_i) begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end else if (mode_q == PERIODIC) begin
                    cnt_q <= reload_q;
                end else begin
                    state_q <= IDLE;
                end
            end
        end
    end

    assign tc_o    = tc_q;
    assign cnt_o   = cnt_q;
    assign state_o = state_q;

endmodule

// File: rtl/multi_chan_down_counter.sv
// Bank of NUM_CH down counters sharing one command port (valid/ready).
// Define MULTI_CHAN_DOWN_COUNTER_STICKY_EN for per-channel sticky tc flags.
module multi_chan_down_counter
    import multi_chan_down_counter_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               NUM_CH    = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH-1:0]           ena,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [ch_idx_w(NUM_CH)-1:0] cmd_ch,
    input  logic [1:0]                  cmd_op,
    input  logic [WIDTH-1:0]            cmd_value,
`ifdef MULTI_CHAN_DOWN_COUNTER_STICKY_EN
    input  logic [NUM_CH-1:0]           tc_clr,
    output logic [NUM_CH-1:0]           tc_sticky,
`endif
    output logic [NUM_CH-1:0]           tc,
    output logic [NUM_CH*WIDTH-1:0]     cnt,
    output logic [NUM_CH-1:0]           busy
);

    localparam int CH_W = ch_idx_w(NUM_CH);

    // Handshake: a command is taken on any edge with cmd_valid && cmd_ready.
    // cmd_ready rises one edge after reset release and then stays high.
    logic    ready_q;
    cmd_op_e op;
    logic    ch_ok;
    logic    accept;
    logic    is_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    assign cmd_ready = ready_q;
    assign op        = cmd_op_e'(cmd_op);
    assign ch_ok     = ({1'b0, cmd_ch} < (CH_W+1)'(NUM_CH));
    assign accept    = cmd_valid && ready_q && ch_ok;
    assign is_load   = (op == LOAD_ONESHOT) || (op == LOAD_PERIODIC);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic        sel;
        chan_state_e state;

        assign sel = accept && (cmd_ch == CH_W'(g));

        multi_chan_down_counter_chan #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .ena_i      (ena[g]),
            .load_i     (sel && is_load),
            .stop_i     (sel && (op == STOP)),
            .periodic_i (op == LOAD_PERIODIC),
            .value_i    (cmd_value),
            .tc_o       (tc[g]),
            .cnt_o      (cnt[g*WIDTH +: WIDTH]),
            .state_o    (state)
        );

        assign busy[g] = (state == RUN);
    end

`ifdef MULTI_CHAN_DOWN_COUNTER_STICKY_EN
    logic [NUM_CH-1:0] sticky_q;
    logic [NUM_CH-1:0] sticky_set;

    // Same expiry condition the channel registers into tc, so the flag rises with tc.
    for (genvar s = 0; s < NUM_CH; s++) begin : g_set
        assign sticky_set[s] = busy[s] && ena[s] && (cnt[s*WIDTH +: WIDTH] == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_set | (sticky_q & ~tc_clr);
        end
    end

    assign tc_sticky = sticky_q;
`endif

endmodule
